// File: rtl/output_device_serializer_pkg.sv
// Shared definitions for the serial output stages.
//
// Contents:
//   DefaultWidth   default frame width in bits (matches the device register width)
//   DefaultClkDiv  default system-clock cycles per ser_clk phase and per latch pulse
//   ser_state_t    2-bit FSM state type, with fixed state encodings
//
// The state encodings are fixed numeric constants rather than an enum, so that other
// serial output stages and existing tooling that decode the raw state bits stay compatible.
package output_device_serializer_pkg;

  localparam int unsigned DefaultWidth  = 32;
  localparam int unsigned DefaultClkDiv = 2;

  typedef logic [1:0] ser_state_t;

  localparam ser_state_t StIdle  = 2'd0;
  localparam ser_state_t StLow   = 2'd1;
  localparam ser_state_t StHigh  = 2'd2;
  localparam ser_state_t StLatch = 2'd3;

endpackage

// File: rtl/output_device_serializer_phase_timer.sv
// serial_phase_timer: phase-length counter used for every timed phase of a frame.
//
// Ports:
//   clk    in   system clock, rising-edge
//   reset  in   synchronous, active-high reset
//   clear  in   holds the counter at zero (the next phase then starts from a clean count)
//   done   out  high for one cycle on the last cycle of each CLK_DIV-cycle phase
//
// The counter wraps to zero by itself on done. Back-to-back phases (LOW -> HIGH -> LOW ...)
// therefore need no explicit restart.
module serial_phase_timer #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic done
);

  localparam int unsigned CntW = $clog2(CLK_DIV) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign done = !clear && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || done) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/output_device_serializer.sv
// output_device_serializer: mirrors one output-device register onto a 74HC595-style
// shift-register chain.
//
// Whenever device_value differs from the last value sent, a snapshot is shifted out
// MSB-first and then latched into the chain's storage register. Changes arriving while a
// frame is in flight are not sampled; the first idle cycle after the frame compares against
// the last value sent, so any number of intermediate changes collapse into one follow-up frame.
//
// Ports:
//   clk           in   system clock, rising-edge
//   reset         in   synchronous, active-high reset (aborts a frame in flight, no latch)
//   device_value  in   current output-device register contents
//   ser_data      out  serial data, stable through the whole ser_clk high phase
//   ser_clk       out  shift clock; the chain samples on its rising edge
//   ser_latch     out  storage-register latch pulse, CLK_DIV cycles after the last bit
//   busy          out  high while a frame (shift + latch) is in progress
//   frame_count   out  completed frames, wrapping at 16 bits
//
// All outputs come straight from flops; there is no combinational path from device_value.
module output_device_serializer
  import output_device_serializer_pkg::*;
#(
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned CLK_DIV = DefaultClkDiv
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] device_value,
  output logic             ser_data,
  output logic             ser_clk,
  output logic             ser_latch,
  output logic             busy,
  output logic [15:0]      frame_count
);

  localparam int unsigned BitW = $clog2(WIDTH) + 1;
  localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] last_sent_q, last_sent_d;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             ser_data_q, ser_data_d;
  logic             ser_clk_q, ser_clk_d;
  logic             ser_latch_q, ser_latch_d;
  logic             busy_q, busy_d;

  logic             phase_done;
  logic [WIDTH-1:0] shadow_next;

  // The timer is held at zero while idle, so the first LOW phase starts from a fresh count.
  serial_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_timer (
    .clk   (clk),
    .reset (reset),
    .clear (state_q == StIdle),
    .done  (phase_done)
  );

  // The next bit to present is the MSB of the shadow after this shift.
  assign shadow_next = shadow_q << 1;

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    last_sent_d   = last_sent_q;
    bit_cnt_d     = bit_cnt_q;
    frame_count_d = frame_count_q;
    ser_data_d    = ser_data_q;
    ser_clk_d     = ser_clk_q;
    ser_latch_d   = ser_latch_q;
    busy_d        = busy_q;

    unique case (state_q)
      StIdle: begin
        if (device_value != last_sent_q) begin
          shadow_d    = device_value;
          last_sent_d = device_value;
          bit_cnt_d   = BitLast;
          ser_clk_d   = 1'b0;
          ser_data_d  = device_value[WIDTH-1];
          busy_d      = 1'b1;
          state_d     = StLow;
        end
      end

      StLow: begin
        if (phase_done) begin
          ser_clk_d = 1'b1;
          state_d   = StHigh;
        end
      end

      StHigh: begin
        if (phase_done) begin
          shadow_d  = shadow_next;
          ser_clk_d = 1'b0;
          if (bit_cnt_q == '0) begin
            // Park the data line low while latching so the idle bus is quiet.
            ser_data_d  = 1'b0;
            ser_latch_d = 1'b1;
            state_d     = StLatch;
          end else begin
            bit_cnt_d  = bit_cnt_q - 1'b1;
            ser_data_d = shadow_next[WIDTH-1];
            state_d    = StLow;
          end
        end
      end

      StLatch: begin
        if (phase_done) begin
          ser_latch_d   = 1'b0;
          busy_d        = 1'b0;
          frame_count_d = frame_count_q + 16'd1;
          state_d       = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      shadow_q      <= '0;
      last_sent_q   <= '0;
      bit_cnt_q     <= '0;
      frame_count_q <= '0;
      ser_data_q    <= 1'b0;
      ser_clk_q     <= 1'b0;
      ser_latch_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      last_sent_q   <= last_sent_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_count_q <= frame_count_d;
      ser_data_q    <= ser_data_d;
      ser_clk_q     <= ser_clk_d;
      ser_latch_q   <= ser_latch_d;
      busy_q        <= busy_d;
    end
  end

  assign ser_data    = ser_data_q;
  assign ser_clk     = ser_clk_q;
  assign ser_latch   = ser_latch_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_output_device_serializer.sv
// Bench for output_device_serializer: a default 32-bit/CLK_DIV=2 instance and an
// 8-bit/CLK_DIV=1 instance. Each has a model of the external 74HC595 chain (shift register on
// ser_clk rise, storage register on ser_latch rise) and a scoreboard queue of expected frames.
module tb_output_device_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] value = 32'h0;
  logic        ser_data, ser_clk, ser_latch, busy;
  logic [15:0] frame_count;

  logic [7:0]  s_value = 8'h0;
  logic        s_ser_data, s_ser_clk, s_ser_latch, s_busy;
  logic [15:0] s_frame_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  output_device_serializer #(
    .WIDTH   (32),
    .CLK_DIV (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .device_value (value),
    .ser_data     (ser_data),
    .ser_clk      (ser_clk),
    .ser_latch    (ser_latch),
    .busy         (busy),
    .frame_count  (frame_count)
  );

  output_device_serializer #(
    .WIDTH   (8),
    .CLK_DIV (1)
  ) dut_small (
    .clk          (clk),
    .reset        (reset),
    .device_value (s_value),
    .ser_data     (s_ser_data),
    .ser_clk      (s_ser_clk),
    .ser_latch    (s_ser_latch),
    .busy         (s_busy),
    .frame_count  (s_frame_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- main-instance monitor
  logic [31:0] exp_q[$];
  logic [31:0] sh_m = 32'h0;
  logic [31:0] store_m = 32'h0;
  int          busy_len = 0, clk_edges = 0, latch_pulses = 0, total_edges = 0;
  logic        busy_p = 1'b0, clk_p = 1'b0, latch_p = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      busy_len = 0; clk_edges = 0; latch_pulses = 0;
      busy_p = 1'b0; clk_p = 1'b0; latch_p = 1'b0;
    end else begin
      if (ser_clk && !clk_p) begin
        sh_m = {sh_m[30:0], ser_data};
        clk_edges++;
        total_edges++;
      end
      if (ser_latch && !latch_p) begin
        store_m = sh_m;
        latch_pulses++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got storage %h, expected no frame", store_m);
        end else begin
          check("frame_value", store_m, exp_q.pop_front());
        end
      end
      if (busy) busy_len++;
      if (!busy && busy_p) begin
        check("busy_cycles", busy_len, 32'd130);
        check("ser_clk_edges", clk_edges, 32'd32);
        check("latch_pulses", latch_pulses, 32'd1);
        busy_len = 0; clk_edges = 0; latch_pulses = 0;
      end
      busy_p = busy; clk_p = ser_clk; latch_p = ser_latch;
    end
  end

  // ---------------------------------------------------------------- small-instance monitor
  logic [7:0] s_exp_q[$];
  logic [7:0] s_sh_m = 8'h0;
  logic [7:0] s_store_m = 8'h0;
  int         s_clk_edges = 0;
  logic       s_clk_p = 1'b0, s_latch_p = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (s_ser_clk && !s_clk_p) begin
        s_sh_m = {s_sh_m[6:0], s_ser_data};
        s_clk_edges++;
      end
      if (s_ser_latch && !s_latch_p) begin
        s_store_m = s_sh_m;
        if (s_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL small_unexpected_frame: got storage %h, expected no frame", s_store_m);
        end else begin
          check("small_frame_value", {24'h0, s_store_m}, {24'h0, s_exp_q.pop_front()});
        end
      end
    end
    s_clk_p = s_ser_clk; s_latch_p = s_ser_latch;
  end

  task automatic wait_busy(input logic lvl, input int limit, input string name);
    int n = 0;
    while (busy !== lvl && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'h0, busy}, {31'h0, lvl});
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_ser_data"}, {31'h0, ser_data}, 32'h0);
    check({name, "_ser_clk"}, {31'h0, ser_clk}, 32'h0);
    check({name, "_ser_latch"}, {31'h0, ser_latch}, 32'h0);
    check({name, "_busy"}, {31'h0, busy}, 32'h0);
    check({name, "_frame_count"}, {16'h0, frame_count}, 32'h0);
  endtask

  initial begin
    int gap;
    int s_len;

    // 1: reset, then an all-zero register produces nothing.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    repeat (200) @(negedge clk);
    check_idle_outputs("zero_hold");
    check("zero_hold_edges", total_edges, 32'd0);

    // 2 + 3: first frame, with two mid-frame writes collapsing into one follow-up.
    value = 32'hE5F84AB1;
    exp_q.push_back(32'hE5F84AB1);
    exp_q.push_back(32'h12345678);
    wait_busy(1'b1, 5, "frame1_start");
    repeat (20) @(negedge clk);
    value = 32'h5C8C6A01;
    repeat (20) @(negedge clk);
    value = 32'h12345678;
    wait_busy(1'b0, 200, "frame1_end");
    check("frame1_count", {16'h0, frame_count}, 32'd1);
    gap = 0;
    while (!busy && gap < 10) begin
      @(negedge clk);
      gap++;
    end
    check("idle_gap", gap, 32'd1);
    wait_busy(1'b0, 200, "frame2_end");
    check("frame2_count", {16'h0, frame_count}, 32'd2);
    check("frame2_storage", store_m, 32'h12345678);

    // 4: A -> B -> A during a frame sends nothing extra.
    value = 32'hCAFEF00D;
    exp_q.push_back(32'hCAFEF00D);
    wait_busy(1'b1, 5, "frame3_start");
    repeat (30) @(negedge clk);
    value = 32'h11111111;
    repeat (30) @(negedge clk);
    value = 32'hCAFEF00D;
    wait_busy(1'b0, 200, "frame3_end");
    repeat (20) @(negedge clk);
    check("aba_busy", {31'h0, busy}, 32'h0);
    check("aba_count", {16'h0, frame_count}, 32'd3);

    // 5: reset at cycle 40 of a frame aborts it without a latch.
    value = 32'hE5F84AB1;
    wait_busy(1'b1, 5, "abort_start");
    repeat (39) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort");
    check("abort_storage", store_m, 32'hCAFEF00D);
    exp_q.push_back(32'hE5F84AB1);
    reset = 1'b0;
    wait_busy(1'b1, 5, "restart_start");
    wait_busy(1'b0, 200, "restart_end");
    check("restart_count", {16'h0, frame_count}, 32'd1);
    check("restart_storage", store_m, 32'hE5F84AB1);

    // 6: WIDTH=8, CLK_DIV=1 instance.
    s_value = 8'hA5;
    s_exp_q.push_back(8'hA5);
    s_len = 0;
    while (!s_busy && s_len < 5) begin
      @(negedge clk);
      s_len++;
    end
    check("small_start", {31'h0, s_busy}, 32'h1);
    s_len = 0;
    while (s_busy && s_len < 100) begin
      @(negedge clk);
      s_len++;
    end
    check("small_busy_cycles", s_len, 32'd17);
    check("small_edges", s_clk_edges, 32'd8);
    check("small_storage", {24'h0, s_store_m}, 32'h000000A5);
    check("small_count", {16'h0, s_frame_count}, 32'd1);

    repeat (5) @(negedge clk);
    check("pending_frames", exp_q.size(), 32'd0);
    check("small_pending_frames", s_exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
